// File: rtl/btn_pkg.sv
// Shared types and defaults for the button debouncer.
// States use a Gray-style encoding so that each legal transition flips a single bit.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } btn_state_e;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int STABLE_TICKS_DEF = 4;

  // The debounced level is 1 while settled high or while a fall is still only a candidate.
  function automatic logic level_of(input logic [1:0] st);
    return (st == S_HIGH) || (st == S_FALL);
  endfunction

endpackage

// File: rtl/btn_if.sv
// Bundles the debouncer's sample qualifier, raw input, conditioned outputs and debug taps.
// The slave side is the debouncer; the master side is whoever drives the raw button.
interface btn_if #(
  parameter int CNT_W = 3
);

  logic             tick_i;
  logic             btn_in_i;
  logic             level_o;
  logic             press_o;
  logic             release_o;
  logic             toggle_o;
  logic [1:0]       dbg_state_o;
  logic [CNT_W-1:0] dbg_cnt_o;

  modport slave (
    input  tick_i,
    input  btn_in_i,
    output level_o,
    output press_o,
    output release_o,
    output toggle_o,
    output dbg_state_o,
    output dbg_cnt_o
  );

  modport master (
    output tick_i,
    output btn_in_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  toggle_o,
    input  dbg_state_o,
    input  dbg_cnt_o
  );

endinterface

// File: rtl/btn_debounce_sync_ff.sv
// N-stage flop synchroniser with synchronous reset to 0.
// Reusable for any single-bit or narrow asynchronous input entering the clk domain.
module sync_ff #(
  parameter int N     = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/btn_debounce.sv
// Synchronises a raw button, debounces it with a tick-qualified stability counter,
// and produces a clean level, press/release pulses and a press-toggled enable.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic  clk,
  input  logic  rst,
  btn_if.slave  bus
);

  localparam int               CNT_W    = $clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  localparam logic [1:0] ST_LOW  = S_LOW;
  localparam logic [1:0] ST_RISE = S_RISE;
  localparam logic [1:0] ST_HIGH = S_HIGH;
  localparam logic [1:0] ST_FALL = S_FALL;

  logic             s;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic             accept_rise, accept_fall;

  sync_ff #(
    .N     (SYNC_STAGES),
    .WIDTH (1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.btn_in_i),
    .q_o (s)
  );

  assign tick = bus.tick_i;

  // Candidate states count qualified ticks; any disagreement of s is a bounce back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_RISE;
          cnt_d   = '0;
        end
      end
      ST_RISE: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (tick && (cnt_q == CNT_LAST)) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_FALL;
          cnt_d   = '0;
        end
      end
      ST_FALL: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (tick && (cnt_q == CNT_LAST)) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they move on the same edge as the FSM.
  always_comb begin
    accept_rise = (state_q == ST_RISE) && (state_d == ST_HIGH);
    accept_fall = (state_q == ST_FALL) && (state_d == ST_LOW);
    level_d     = level_of(state_d);
    press_d     = accept_rise;
    release_d   = accept_fall;
    toggle_d    = toggle_q ^ accept_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign bus.level_o     = level_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.toggle_o    = toggle_q;
  assign bus.dbg_state_o = state_q;
  assign bus.dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: expected press/release events (cycle + toggle value) are queued
// when the button is driven and matched against every pulse the DUT emits.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int SYNC  = 2;
  localparam int TICKS = 4;
  localparam int CNT_W = $clog2(TICKS) + 1;
  localparam int LAT   = SYNC + TICKS + 1;
  localparam int W     = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_if #(.CNT_W(CNT_W)) bus ();

  btn_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_TICKS (TICKS)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int           checks  = 0;
  int           errors  = 0;
  logic         exp_tog = 1'b0;
  logic         tick_gated = 1'b0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] evt(input logic [1:0] kind, input logic tog, input int at);
    return {kind, tog, at[28:0]};
  endfunction

  task automatic push_press(input int at);
    exp_tog = ~exp_tog;
    exp_q.push_back(evt(2'd1, exp_tog, at));
  endtask

  task automatic push_release(input int at);
    exp_q.push_back(evt(2'd2, exp_tog, at));
  endtask

  // Acceptance edge when ticks arrive only on edges numbered 0 mod 4: the candidate is
  // entered SYNC+1 edges after the drive, then TICKS further tick edges are needed.
  function automatic int gated_at(input int c);
    int e = c + SYNC + 2;
    int k = 0;
    while (k < TICKS) begin
      if (e % 4 == 0) k++;
      if (k < TICKS) e++;
    end
    return e;
  endfunction

  // Tick driver: full rate, or one edge in four when gated.
  always @(negedge clk) begin
    bus.tick_i = tick_gated ? (cyc % 4 == 3) : 1'b1;
  end

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.press_o) begin
      if (exp_q.size() == 0) check_val("unexpected_press", evt(2'd1, bus.toggle_o, cyc), '0);
      else                   check_val("press_event", evt(2'd1, bus.toggle_o, cyc), exp_q.pop_front());
    end
    if (bus.release_o) begin
      if (exp_q.size() == 0) check_val("unexpected_release", evt(2'd2, bus.toggle_o, cyc), '0);
      else                   check_val("release_event", evt(2'd2, bus.toggle_o, cyc), exp_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_in_i = 1'b1;

    // Reset held with the button pressed.
    wait_cyc(3);
    check_val("rst_level",   bus.level_o,     0);
    check_val("rst_press",   bus.press_o,     0);
    check_val("rst_release", bus.release_o,   0);
    check_val("rst_toggle",  bus.toggle_o,    0);
    check_val("rst_state",   bus.dbg_state_o, S_LOW);
    check_val("rst_cnt",     bus.dbg_cnt_o,   0);
    rst = 1'b0;
    push_press(cyc + LAT);
    wait_cyc(12);
    check_val("t1_level_high", bus.level_o, 1);

    // Clean release and press at full rate.
    bus.btn_in_i = 1'b0;
    push_release(cyc + LAT);
    wait_cyc(15);
    check_val("t2_level_low", bus.level_o, 0);
    bus.btn_in_i = 1'b1;
    push_press(cyc + LAT);
    wait_cyc(15);
    check_val("t2_level_high", bus.level_o, 1);

    // Falling bounce while high: no release.
    bus.btn_in_i = 1'b0; wait_cyc(3);
    bus.btn_in_i = 1'b1; wait_cyc(12);
    check_val("fall_bounce_level", bus.level_o, 1);
    check_val("fall_bounce_state", bus.dbg_state_o, S_HIGH);
    bus.btn_in_i = 1'b0;
    push_release(cyc + LAT);
    wait_cyc(15);

    // Rising bounce 3/2/2: no press, counter back to 0.
    bus.btn_in_i = 1'b1; wait_cyc(3);
    bus.btn_in_i = 1'b0; wait_cyc(2);
    bus.btn_in_i = 1'b1; wait_cyc(2);
    bus.btn_in_i = 1'b0; wait_cyc(12);
    check_val("bounce_level", bus.level_o, 0);
    check_val("bounce_state", bus.dbg_state_o, S_LOW);
    check_val("bounce_cnt",   bus.dbg_cnt_o, 0);

    // Window boundary: 4-cycle pulse rejected, 5-cycle pulse accepted.
    bus.btn_in_i = 1'b1; wait_cyc(4);
    bus.btn_in_i = 1'b0; wait_cyc(12);
    check_val("pulse4_level", bus.level_o, 0);
    bus.btn_in_i = 1'b1;
    push_press(cyc + LAT);
    wait_cyc(5);
    bus.btn_in_i = 1'b0;
    push_release(cyc + LAT);
    wait_cyc(15);
    check_val("pulse5_level", bus.level_o, 0);

    // Tick gating: one tick every fourth clock.
    tick_gated = 1'b1;
    wait_cyc(5);
    bus.btn_in_i = 1'b1;
    push_press(gated_at(cyc));
    wait_cyc(30);
    check_val("gated_level_high", bus.level_o, 1);
    bus.btn_in_i = 1'b0;
    push_release(gated_at(cyc));
    wait_cyc(30);
    check_val("gated_level_low", bus.level_o, 0);
    bus.btn_in_i = 1'b1; wait_cyc(8);
    bus.btn_in_i = 1'b0; wait_cyc(30);
    check_val("gated_early_drop", bus.level_o, 0);
    tick_gated = 1'b0;
    wait_cyc(4);

    // Three presses: toggle must alternate.
    for (int i = 0; i < 3; i++) begin
      bus.btn_in_i = 1'b1;
      push_press(cyc + LAT);
      wait_cyc(10);
      check_val("seq_toggle", bus.toggle_o, exp_tog);
      bus.btn_in_i = 1'b0;
      push_release(cyc + LAT);
      wait_cyc(10);
    end
    check_val("seq_drained", exp_q.size(), 0);

    // Reset while rising candidate has counted two ticks.
    bus.btn_in_i = 1'b1;
    wait_cyc(5);
    check_val("mid_state", bus.dbg_state_o, S_RISE);
    check_val("mid_cnt",   bus.dbg_cnt_o, 2);
    rst = 1'b1;
    wait_cyc(1);
    check_val("mid_rst_state",  bus.dbg_state_o, S_LOW);
    check_val("mid_rst_cnt",    bus.dbg_cnt_o, 0);
    check_val("mid_rst_toggle", bus.toggle_o, 0);
    rst     = 1'b0;
    exp_tog = 1'b0;
    push_press(cyc + LAT);
    wait_cyc(12);
    check_val("mid_level", bus.level_o, 1);
    bus.btn_in_i = 1'b0;
    push_release(cyc + LAT);
    wait_cyc(15);

    check_val("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
